// File: rtl/fpu_pkg.sv
// Shared FP32 field layout, flag indices and rounding-mode encodings for the FPU
// multiplier scheduling logic.
package fpu_pkg;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned FP_W     = 1 + EXP_W + MAN_W;

    localparam int unsigned FLAG_W         = 5;
    localparam int unsigned FLAG_INVALID   = 4;
    localparam int unsigned FLAG_OVERFLOW  = 3;
    localparam int unsigned FLAG_UNDERFLOW = 2;
    localparam int unsigned FLAG_INEXACT   = 1;
    localparam int unsigned FLAG_ZERO      = 0;

    typedef enum logic [1:0] {
        RM_NEAREST_EVEN = 2'b00,
        RM_TO_ZERO      = 2'b01,
        RM_TO_POS       = 2'b10,
        RM_TO_NEG       = 2'b11
    } rmode_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/fpu_mul_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, with wrap-around,
// and moves the pointer just past the winner whenever the grant is taken.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic          found;
    int            j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < int'(N); k++) begin
            j = int'(ptr_q) + k;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            if (!found && en && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/fpu_mul_sched.sv
// Shares one pipelined FP32 multiplier core between NREQ requesters: round-robin issue,
// a tag pipeline matched to the core latency, and per-requester result strobes.
module fpu_mul_sched
    import fpu_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         sched_en,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [FP_W*NREQ-1:0]         req_opa,
    input  logic [FP_W*NREQ-1:0]         req_opb,
    input  logic [2*NREQ-1:0]            req_rmode,
    output logic                         mul_Sx,
    output logic                         mul_Sy,
    output logic [EXP_W-1:0]             mul_Ex,
    output logic [EXP_W-1:0]             mul_Ey,
    output logic [MAN_W-1:0]             mul_Mx,
    output logic [MAN_W-1:0]             mul_My,
    output logic [1:0]                   mul_rmode,
    output logic [1:0]                   mul_enable,
    input  logic                         mul_Sz,
    input  logic [EXP_W-1:0]             mul_Ez,
    input  logic [MAN_W-1:0]             mul_Mz,
    input  logic [FLAG_W-1:0]            mul_flags,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [FP_W-1:0]              rsp_data,
    output logic [FLAG_W-1:0]            rsp_flags,
    output logic [$clog2(MUL_LAT+1)-1:0] in_flight
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(MUL_LAT + 1);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            handshake;
    logic            retire;

    fp32_t      sel_a;
    fp32_t      sel_b;
    logic [1:0] sel_rm;

    logic [MUL_LAT-1:0] tag_valid_q;
    logic [IDW-1:0]     tag_id_q [MUL_LAT];
    logic [CW-1:0]      in_flight_q;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req_valid),
        .en        (sched_en),
        .advance   (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign handshake = |(req_valid & grant);

    // Operand mux: all-zero fields whenever nothing is granted.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_rm = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                sel_a  = fp32_t'(req_opa[FP_W*i +: FP_W]);
                sel_b  = fp32_t'(req_opb[FP_W*i +: FP_W]);
                sel_rm = req_rmode[2*i +: 2];
            end
        end
    end

    assign mul_Sx     = sel_a.sign;
    assign mul_Ex     = sel_a.exp;
    assign mul_Mx     = sel_a.man;
    assign mul_Sy     = sel_b.sign;
    assign mul_Ey     = sel_b.exp;
    assign mul_My     = sel_b.man;
    assign mul_rmode  = sel_rm;
    assign mul_enable = {2{handshake}};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tag_valid_q <= '0;
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_valid_q[0] <= handshake;
            tag_id_q[0]    <= grant_idx;
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end
        end
    end

    assign retire = tag_valid_q[MUL_LAT-1];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (tag_id_q[MUL_LAT-1] == IDW'(i)) begin
                rsp_valid[i] = retire;
            end
        end
    end

    assign rsp_data  = {mul_Sz, mul_Ez, mul_Mz};
    // The core holds its last result between issues, so flags are masked when nothing retires.
    assign rsp_flags = retire ? mul_flags : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            in_flight_q <= '0;
        end else begin
            unique case ({handshake, retire})
                2'b10:   in_flight_q <= in_flight_q + CW'(1);
                2'b01:   in_flight_q <= in_flight_q - CW'(1);
                default: in_flight_q <= in_flight_q;
            endcase
        end
    end

    assign in_flight = in_flight_q;

endmodule

// File: tb/tb_fpu_mul_sched.sv
// Bench for fpu_mul_sched: a stand-in multiplier core, a queue-based scoreboard checked
// every cycle, and directed scenarios with literal expectations.
module tb_fpu_mul_sched;

    localparam int NREQ    = 2;
    localparam int MUL_LAT = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              sched_en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [32*NREQ-1:0] req_opa;
    logic [32*NREQ-1:0] req_opb;
    logic [2*NREQ-1:0] req_rmode;
    logic              mul_Sx, mul_Sy;
    logic [7:0]        mul_Ex, mul_Ey;
    logic [22:0]       mul_Mx, mul_My;
    logic [1:0]        mul_rmode;
    logic [1:0]        mul_enable;
    logic              mul_Sz;
    logic [7:0]        mul_Ez;
    logic [22:0]       mul_Mz;
    logic [4:0]        mul_flags;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_data;
    logic [4:0]        rsp_flags;
    logic [$clog2(MUL_LAT+1)-1:0] in_flight;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 CLK = ~CLK;

    fpu_mul_sched #(
        .NREQ    (NREQ),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .sched_en   (sched_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_rmode  (req_rmode),
        .mul_Sx     (mul_Sx),
        .mul_Sy     (mul_Sy),
        .mul_Ex     (mul_Ex),
        .mul_Ey     (mul_Ey),
        .mul_Mx     (mul_Mx),
        .mul_My     (mul_My),
        .mul_rmode  (mul_rmode),
        .mul_enable (mul_enable),
        .mul_Sz     (mul_Sz),
        .mul_Ez     (mul_Ez),
        .mul_Mz     (mul_Mz),
        .mul_flags  (mul_flags),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .in_flight  (in_flight)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in core: exact answers for the directed vectors, an arbitrary mix otherwise.
    function automatic logic [36:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm);
        if (a == 32'h3FC00000 && b == 32'h40000000) return {5'b00000, 32'h40400000};
        if ((a[30:0] == 31'h7F800000 && b[30:0] == 31'h0) ||
            (b[30:0] == 31'h7F800000 && a[30:0] == 31'h0)) return {5'b10000, 32'h7FC00000};
        return {5'b00010, a[31] ^ b[31], a[30:0] + b[30:0] + {29'b0, rm}};
    endfunction

    logic        s0_en;
    logic [36:0] s0_res;
    logic [36:0] core_q;

    // Two register stages; the output register holds its value between results.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0_en  <= 1'b0;
            s0_res <= '0;
            core_q <= '0;
        end else begin
            s0_en  <= (mul_enable == 2'b11);
            s0_res <= core_fn({mul_Sx, mul_Ex, mul_Mx}, {mul_Sy, mul_Ey, mul_My}, mul_rmode);
            if (s0_en) core_q <= s0_res;
        end
    end

    assign {mul_flags, mul_Sz, mul_Ez, mul_Mz} = core_q;

    // Scoreboard: every accepted request becomes a result due MUL_LAT cycles later.
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    exp_t q[$];
    int   ptr_m = 0;
    int   cyc   = 0;

    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input logic en,
                                                   input int p);
        logic [NREQ-1:0] g = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx = (p + k) % NREQ;
            if (en && v[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    always @(posedge CLK or negedge RST) begin : model
        logic [NREQ-1:0] g;
        logic [36:0]     res;
        if (!RST) begin
            q.delete();
            ptr_m = 0;
        end else begin
            g = model_grant(req_valid, sched_en, ptr_m);
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    res = core_fn(req_opa[32*i +: 32], req_opb[32*i +: 32], req_rmode[2*i +: 2]);
                    q.push_back('{cyc + MUL_LAT, i, res[31:0], res[36:32]});
                    ptr_m = (i + 1) % NREQ;
                end
            end
            cyc++;
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        end
    end

    always @(negedge CLK) begin : compare
        logic [NREQ-1:0] exp_v;
        logic [NREQ-1:0] exp_g;
        logic [31:0]     exp_d, exp_a, exp_b;
        logic [4:0]      exp_f;
        logic [1:0]      exp_rm;
        int              n;
        if (chk_on) begin
            exp_v = '0; exp_d = '0; exp_f = '0; n = 0;
            foreach (q[k]) begin
                if (q[k].due == cyc) begin
                    exp_v[q[k].id] = 1'b1;
                    exp_d = q[k].data;
                    exp_f = q[k].flags;
                end
                if (q[k].due - MUL_LAT < cyc) n++;
            end
            exp_g = model_grant(req_valid, sched_en, ptr_m);
            exp_a = '0; exp_b = '0; exp_rm = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_g[i]) begin
                    exp_a  = req_opa[32*i +: 32];
                    exp_b  = req_opb[32*i +: 32];
                    exp_rm = req_rmode[2*i +: 2];
                end
            end
            check("req_ready", req_ready, exp_g);
            check("mul_opa", {mul_Sx, mul_Ex, mul_Mx}, exp_a);
            check("mul_opb", {mul_Sy, mul_Ey, mul_My}, exp_b);
            check("mul_rmode", mul_rmode, exp_rm);
            check("mul_enable", mul_enable, (exp_g != 0) ? 2'b11 : 2'b00);
            check("rsp_valid", rsp_valid, exp_v);
            check("rsp_flags", rsp_flags, exp_f);
            if (exp_v != 0) check("rsp_data", rsp_data, exp_d);
            check("in_flight", in_flight, n);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm);
        req_opa[32*i +: 32] = a;
        req_opb[32*i +: 32] = b;
        req_rmode[2*i +: 2] = rm;
    endtask

    logic [NREQ-1:0] got [4];

    initial begin
        RST = 1'b0; sched_en = 1'b1; req_valid = '0;
        req_opa = '0; req_opb = '0; req_rmode = '0;
        step(); step();
        @(negedge CLK);
        check("reset_rsp_valid", rsp_valid, 2'b00);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_rsp_flags", rsp_flags, 5'h0);
        check("reset_in_flight", in_flight, 0);
        check("reset_req_ready", req_ready, 2'b00);
        chk_on = 1'b1;
        step();
        RST = 1'b1;
        step(); step();

        // Single op on req0: 1.5 * 2.0
        set_req(0, 32'h3FC00000, 32'h40000000, 2'b00);
        req_valid = 2'b01;
        @(negedge CLK);
        check("single_ready", req_ready, 2'b01);
        check("single_Ex", mul_Ex, 8'h7F);
        check("single_Mx", mul_Mx, 23'h400000);
        check("single_Ey", mul_Ey, 8'h80);
        step(); req_valid = '0;
        step();
        @(negedge CLK);
        check("single_rsp_valid", rsp_valid, 2'b01);
        check("single_rsp_data", rsp_data, 32'h40400000);
        check("single_rsp_flags", rsp_flags, 5'b00000);
        step();

        // Flag routing: inf * 0 on req1
        set_req(1, 32'h7F800000, 32'h00000000, 2'b01);
        req_valid = 2'b10;
        step(); req_valid = '0;
        step();
        @(negedge CLK);
        check("flag_rsp_valid", rsp_valid, 2'b10);
        check("flag_rsp_data", rsp_data, 32'h7FC00000);
        check("flag_rsp_flags", rsp_flags, 5'b10000);
        step();

        // Contention from ptr=0
        for (int k = 0; k < 4; k++) begin
            set_req(0, 32'h3F800000 + k, 32'h40000000 + 16 * k, 2'b10);
            set_req(1, 32'h40400000 + k, 32'hC0000000 + 16 * k, 2'b11);
            req_valid = 2'b11;
            @(negedge CLK);
            got[k] = req_ready;
            if (k == 3) check("cont_in_flight_sat", in_flight, MUL_LAT);
            step();
        end
        req_valid = '0;
        check("cont_grant0", got[0], 2'b01);
        check("cont_grant1", got[1], 2'b10);
        check("cont_grant2", got[2], 2'b01);
        check("cont_grant3", got[3], 2'b10);
        repeat (4) step();

        // Fairness: req1 held, req0 pulses once
        set_req(0, 32'h3F000000, 32'h3F000000, 2'b00);
        req_valid = 2'b10;
        @(negedge CLK); check("fair_r1_a", req_ready, 2'b10);
        step();
        req_valid = 2'b11;
        @(negedge CLK); check("fair_r0", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        @(negedge CLK); check("fair_r1_b", req_ready, 2'b10);
        step();
        req_valid = '0;
        repeat (4) step();

        // sched_en low blocks grants while an issued op still drains
        req_valid = 2'b01;
        step();
        sched_en = 1'b0; req_valid = 2'b11;
        @(negedge CLK); check("dis_ready_a", req_ready, 2'b00);
        step();
        @(negedge CLK);
        check("dis_ready_b", req_ready, 2'b00);
        check("dis_drain_rsp", rsp_valid, 2'b01);
        step();
        @(negedge CLK); check("dis_ready_c", req_ready, 2'b00);
        step();
        sched_en = 1'b1; req_valid = '0;
        repeat (3) step();

        // Reset mid-operation: ptr=1 here, so grants go 1 then 0
        req_valid = 2'b11;
        step(); step();
        req_valid = '0;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_in_flight", in_flight, 0);
        step();
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("rst_no_rsp", rsp_valid, 2'b00);
            step();
        end
        req_valid = 2'b11;
        @(negedge CLK); check("rst_first_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
        repeat (4) step();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fpu_mul_sched.md
# fpu_mul_sched

Round-robin scheduler that shares one fully pipelined FP32 multiplier core between `NREQ` requesters. It accepts one operation per cycle over valid/ready handshakes and splits the IEEE-754 operands into the sign/exponent/mantissa fields the core expects. It tracks in-flight operations with a tag pipeline matched to the core latency and routes each result and its flags back to the requester that issued it. It sits between the FPU issue logic and the multiplier core.

## Interface

Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `MUL_LAT`, default 2: cycles from operands presented to the core until its registered outputs are valid.

Ports:
- `CLK`, in, 1: clock.
- `RST`, in, 1: reset, asynchronous, active-low.
- `sched_en`, in, 1: when 0, no new grants are made; in-flight operations still drain.
- `req_valid`, in, NREQ: request pending, one bit per requester.
- `req_ready`, out, NREQ: one-hot grant, or all zero.
- `req_opa`, in, 32*NREQ: operand A per requester, packed FP32.
- `req_opb`, in, 32*NREQ: operand B per requester, packed FP32.
- `req_rmode`, in, 2*NREQ: rounding mode per requester.
- `mul_Sx`/`mul_Sy`, out, 1 each: sign fields to the core.
- `mul_Ex`/`mul_Ey`, out, 8 each: exponent fields to the core.
- `mul_Mx`/`mul_My`, out, 23 each: mantissa fields to the core.
- `mul_rmode`, out, 2: rounding mode to the core.
- `mul_enable`, out, 2: 2'b11 on issue cycles, else 2'b00.
- `mul_Sz`, `mul_Ez`, `mul_Mz`, in, 1/8/23: result fields from the core.
- `mul_flags`, in, 5: {invalid, overflow, underflow, inexact, zero} from the core.
- `rsp_valid`, out, NREQ: one-hot result strobe, one bit per requester.
- `rsp_data`, out, 32: packed result {Sz,Ez,Mz}, shared by all requesters.
- `rsp_flags`, out, 5: flags of the result, shared by all requesters.
- `in_flight`, out, clog2(MUL_LAT+1): number of operations currently in the core.

## Operation

- Arbitration:
  - Grant = first requester with `req_valid` set, searching from pointer `ptr` upward with wrap-around. Gated by `sched_en`.
  - `req_ready` is combinational from `req_valid`, `ptr` and `sched_en`.
  - Handshake = `req_valid[i] & req_ready[i]`. At most one per cycle.
  - On a handshake, `ptr <= i+1`, wrapping at NREQ-1 → 0. With no handshake, `ptr` holds.
- Operand path:
  - Combinational mux from the granted requester into the core field ports: bit 31 → S, bits 30:23 → E, bits 22:0 → M.
  - With no grant, all `mul_*` operand outputs are 0.
- No backpressure: the core cannot stall and requesters must always accept `rsp_valid`.
- Tag pipeline: shift register of depth MUL_LAT, each entry {valid, id[clog2(NREQ)-1:0]}.
  - Stage 0 loads {handshake, granted id} at every edge.
- Response path:
  - `rsp_valid[id] = valid` of the last stage.
  - `rsp_data` = {mul_Sz, mul_Ez, mul_Mz}.
  - `rsp_flags` = `mul_flags`, passed through while the last stage is valid, else 0.
- `in_flight` = count of valid tag stages, maintained as a counter: +1 on issue, −1 on retire; simultaneous issue and retire leave it unchanged.
- Reset, asynchronous, including mid-operation:
  - `ptr`=0, all tag stages invalid, `in_flight`=0, `rsp_valid`=0.
  - In-flight results are discarded. The core must be reset by the same `RST`.

## Timing

- Issue in cycle t (handshake high before edge t) → `rsp_valid` high during cycle t+MUL_LAT for exactly one cycle.
- Full throughput: one issue per cycle, back-to-back, with no bubbles.
- Responses return in issue order.
- `sched_en` deassert takes effect in the same cycle: no `req_ready`.
- Reset values: `req_ready`=0 while `req_valid`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_flags`=0, `in_flight`=0.

## Structure

- Package `fpu_pkg`:
  - FP32 field widths and positions (SIGN_BIT=31, EXP_W=8, MAN_W=23).
  - Flag vector index constants.
  - Rounding-mode encodings.
- Sub-module `rr_arbiter`: NREQ-wide, with request, enable and advance inputs; outputs one-hot grant and granted index; owns `ptr`.
- Tag pipeline and counter live in the top level.

## Test plan

- Single op: req0 opa=0x3FC00000 (1.5), opb=0x40000000 (2.0), rmode=0 at cycle 5 → `rsp_valid`=2'b01 at cycle 5+MUL_LAT, `rsp_data`=0x40400000, `rsp_flags`=0.
- Contention: req0 and req1 both valid for 4 cycles, ptr=0 → grant order 0,1,0,1; responses alternate in the same order MUL_LAT cycles later; `in_flight` saturates at MUL_LAT.
- Fairness: req1 held valid constantly, req0 pulses once → req0 granted on its first cycle once the pointer reaches it, within ≤ NREQ cycles.
- Flag routing: req1 0x7F800000 × 0x00000000 → `rsp_valid`=2'b10, invalid flag set, output NaN pattern from the core.
- `sched_en`=0 with both requesters valid → `req_ready`=0; already-issued ops still return on schedule.
- `RST` low one cycle after two issues → no `rsp_valid` ever for those ops, `in_flight`=0, and the first grant after reset goes to req0.
